control_unit: RTL and testbench

//  Moore FSM sequencing the datapath: fetch, decode, execute.

---
 rtl/proc_pkg.sv | 36 +++
 rtl/control_unit.sv | 128 ++++++++++++
 tb/tb_control_unit.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/proc_pkg.sv
// Shared definitions for the processor datapath: opcodes, controller state encoding, ALU selects.
package proc_pkg;

    localparam int INSTR_W   = 16;
    localparam int OP_W      = 4;
    localparam int D_ADDR_W  = 8;
    localparam int RF_ADDR_W = 4;
    localparam int ALU_SEL_W = 3;

    typedef enum logic [3:0] {
        OP_NOOP  = 4'b0000,
        OP_STORE = 4'b0001,
        OP_LOAD  = 4'b0010,
        OP_ADD   = 4'b0011,
        OP_SUB   = 4'b0100,
        OP_HALT  = 4'b0101
    } opcode_t;

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_NOOP   = 4'd3,
        S_LOAD_A = 4'd4,
        S_LOAD_B = 4'd5,
        S_STORE  = 4'd6,
        S_ADD    = 4'd7,
        S_SUB    = 4'd8,
        S_HALT   = 4'd9
    } state_t;

    localparam logic [ALU_SEL_W-1:0] ALU_PASS = 3'b000;
    localparam logic [ALU_SEL_W-1:0] ALU_ADD  = 3'b001;
    localparam logic [ALU_SEL_W-1:0] ALU_SUB  = 3'b010;

endpackage

// File: rtl/control_unit.sv
// Moore controller sequencing fetch / decode / execute for the simple load-store datapath.
module control_unit
    import proc_pkg::*;
(
    input  logic                 Clk,
    input  logic                 Reset_N,
    input  logic [INSTR_W-1:0]   IR,
    output logic                 PC_Clr,
    output logic                 PC_Up,
    output logic                 IR_Ld,
    output logic [D_ADDR_W-1:0]  D_Addr,
    output logic                 D_Wr,
    output logic                 RF_s,
    output logic [RF_ADDR_W-1:0] RF_W_Addr,
    output logic                 RF_W_En,
    output logic [RF_ADDR_W-1:0] RF_Ra_Addr,
    output logic [RF_ADDR_W-1:0] RF_Rb_Addr,
    output logic [ALU_SEL_W-1:0] ALU_s0,
    output logic [3:0]           OutState
);

    state_t state_reg;
    state_t state_next;

    logic [OP_W-1:0]      op_field;
    logic [D_ADDR_W-1:0]  load_addr;
    logic [D_ADDR_W-1:0]  store_addr;
    logic [RF_ADDR_W-1:0] ra_field;
    logic [RF_ADDR_W-1:0] rb_field;
    logic [RF_ADDR_W-1:0] wa_field;

    assign op_field   = IR[INSTR_W-1 -: OP_W];
    assign load_addr  = IR[INSTR_W-OP_W-1 -: D_ADDR_W];
    assign store_addr = IR[D_ADDR_W-1:0];
    assign ra_field   = IR[INSTR_W-OP_W-1 -: RF_ADDR_W];
    assign rb_field   = IR[2*RF_ADDR_W-1 -: RF_ADDR_W];
    assign wa_field   = IR[RF_ADDR_W-1:0];

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            state_reg <= S_INIT;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = S_INIT;
        case (state_reg)
            S_INIT:   state_next = S_FETCH;
            S_FETCH:  state_next = S_DECODE;
            S_DECODE: begin
                // Unassigned opcodes fall through to NOOP.
                case (op_field)
                    OP_STORE: state_next = S_STORE;
                    OP_LOAD:  state_next = S_LOAD_A;
                    OP_ADD:   state_next = S_ADD;
                    OP_SUB:   state_next = S_SUB;
                    OP_HALT:  state_next = S_HALT;
                    default:  state_next = S_NOOP;
                endcase
            end
            S_LOAD_A: state_next = S_LOAD_B;
            S_NOOP,
            S_LOAD_B,
            S_STORE,
            S_ADD,
            S_SUB:    state_next = S_FETCH;
            S_HALT:   state_next = S_HALT;
            default:  state_next = S_INIT;
        endcase
    end

    always_comb begin
        PC_Clr     = 1'b0;
        PC_Up      = 1'b0;
        IR_Ld      = 1'b0;
        D_Addr     = '0;
        D_Wr       = 1'b0;
        RF_s       = 1'b0;
        RF_W_Addr  = '0;
        RF_W_En    = 1'b0;
        RF_Ra_Addr = '0;
        RF_Rb_Addr = '0;
        ALU_s0     = ALU_PASS;
        case (state_reg)
            S_INIT: PC_Clr = 1'b1;
            S_FETCH: begin
                IR_Ld = 1'b1;
                PC_Up = 1'b1;
            end
            // RAM read is synchronous: address in LOAD_A, data written back in LOAD_B.
            S_LOAD_A: begin
                D_Addr = load_addr;
                RF_s   = 1'b1;
            end
            S_LOAD_B: begin
                D_Addr    = load_addr;
                RF_s      = 1'b1;
                RF_W_Addr = wa_field;
                RF_W_En   = 1'b1;
            end
            S_STORE: begin
                D_Addr     = store_addr;
                D_Wr       = 1'b1;
                RF_Ra_Addr = ra_field;
            end
            S_ADD: begin
                RF_Ra_Addr = ra_field;
                RF_Rb_Addr = rb_field;
                RF_W_Addr  = wa_field;
                RF_W_En    = 1'b1;
                ALU_s0     = ALU_ADD;
            end
            S_SUB: begin
                RF_Ra_Addr = ra_field;
                RF_Rb_Addr = rb_field;
                RF_W_Addr  = wa_field;
                RF_W_En    = 1'b1;
                ALU_s0     = ALU_SUB;
            end
            default: ;
        endcase
    end

    assign OutState = state_reg;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: steps through each instruction class and checks every output per state.
module tb_control_unit;

    logic        Clk;
    logic        Reset_N;
    logic [15:0] IR;
    logic        PC_Clr, PC_Up, IR_Ld, D_Wr, RF_s, RF_W_En;
    logic [7:0]  D_Addr;
    logic [3:0]  RF_W_Addr, RF_Ra_Addr, RF_Rb_Addr, OutState;
    logic [2:0]  ALU_s0;

    int n_checks = 0;
    int n_fail   = 0;

    control_unit dut (
        .Clk        (Clk),
        .Reset_N    (Reset_N),
        .IR         (IR),
        .PC_Clr     (PC_Clr),
        .PC_Up      (PC_Up),
        .IR_Ld      (IR_Ld),
        .D_Addr     (D_Addr),
        .D_Wr       (D_Wr),
        .RF_s       (RF_s),
        .RF_W_Addr  (RF_W_Addr),
        .RF_W_En    (RF_W_En),
        .RF_Ra_Addr (RF_Ra_Addr),
        .RF_Rb_Addr (RF_Rb_Addr),
        .ALU_s0     (ALU_s0),
        .OutState   (OutState)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Checks state plus every control output against hand-supplied values.
    task automatic expect_all(input string tag, input logic [3:0] st,
                              input logic pc_clr, input logic pc_up, input logic ir_ld,
                              input logic [7:0] d_addr, input logic d_wr, input logic rf_s,
                              input logic [3:0] wa, input logic wen,
                              input logic [3:0] ra, input logic [3:0] rb, input logic [2:0] alu);
        check({tag, ".state"},  {28'd0, OutState}, {28'd0, st});
        check({tag, ".pc_clr"}, {31'd0, PC_Clr},   {31'd0, pc_clr});
        check({tag, ".pc_up"},  {31'd0, PC_Up},    {31'd0, pc_up});
        check({tag, ".ir_ld"},  {31'd0, IR_Ld},    {31'd0, ir_ld});
        check({tag, ".d_addr"}, {24'd0, D_Addr},   {24'd0, d_addr});
        check({tag, ".d_wr"},   {31'd0, D_Wr},     {31'd0, d_wr});
        check({tag, ".rf_s"},   {31'd0, RF_s},     {31'd0, rf_s});
        check({tag, ".w_addr"}, {28'd0, RF_W_Addr}, {28'd0, wa});
        check({tag, ".w_en"},   {31'd0, RF_W_En},  {31'd0, wen});
        check({tag, ".ra"},     {28'd0, RF_Ra_Addr}, {28'd0, ra});
        check({tag, ".rb"},     {28'd0, RF_Rb_Addr}, {28'd0, rb});
        check({tag, ".alu"},    {29'd0, ALU_s0},   {29'd0, alu});
        $display("step %-10s state=%0d pc_clr=%b pc_up=%b ir_ld=%b d_addr=%02h d_wr=%b rf_s=%b wa=%0h wen=%b ra=%0h rb=%0h alu=%03b",
                 tag, OutState, PC_Clr, PC_Up, IR_Ld, D_Addr, D_Wr, RF_s, RF_W_Addr, RF_W_En,
                 RF_Ra_Addr, RF_Rb_Addr, ALU_s0);
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Helpers for the common fixed-output states.
    task automatic expect_fetch(input string tag);
        expect_all(tag, 4'd1, 0, 1, 1, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'b000);
    endtask

    task automatic expect_idle(input string tag, input logic [3:0] st);
        expect_all(tag, st, 0, 0, 0, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'b000);
    endtask

    task automatic expect_init(input string tag);
        expect_all(tag, 4'd0, 1, 0, 0, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'b000);
    endtask

    initial begin
        Reset_N = 1'b0;
        IR      = 16'h3127;
        #1;
        expect_init("rst0");
        step();
        expect_init("rst_hold");
        @(negedge Clk);
        Reset_N = 1'b1;
        step();
        expect_fetch("fetch0");

        // First instruction is ADD; reset it mid-execute.
        step();
        expect_idle("decode0", 4'd2);
        step();
        expect_all("add_pre", 4'd7, 0, 0, 0, 8'h00, 0, 0, 4'h7, 1, 4'h1, 4'h2, 3'b001);
        #2;
        Reset_N = 1'b0;
        #1;
        expect_init("rst_in_add");
        @(negedge Clk);
        Reset_N = 1'b1;
        step();
        expect_fetch("fetch1");

        // LOAD
        IR = 16'h21B5;
        step();
        expect_idle("dec_ld", 4'd2);
        step();
        expect_all("load_a", 4'd4, 0, 0, 0, 8'h1B, 0, 1, 4'h0, 0, 4'h0, 4'h0, 3'b000);
        step();
        expect_all("load_b", 4'd5, 0, 0, 0, 8'h1B, 0, 1, 4'h5, 1, 4'h0, 4'h0, 3'b000);
        step();
        expect_fetch("fetch_ld");

        // STORE
        IR = 16'h13C4;
        step();
        expect_idle("dec_st", 4'd2);
        step();
        expect_all("store", 4'd6, 0, 0, 0, 8'hC4, 1, 0, 4'h0, 0, 4'h3, 4'h0, 3'b000);
        step();
        expect_fetch("fetch_st");

        // ADD
        IR = 16'h3127;
        step();
        expect_idle("dec_add", 4'd2);
        step();
        expect_all("add", 4'd7, 0, 0, 0, 8'h00, 0, 0, 4'h7, 1, 4'h1, 4'h2, 3'b001);
        step();
        expect_fetch("fetch_add");

        // SUB
        IR = 16'h4127;
        step();
        expect_idle("dec_sub", 4'd2);
        step();
        expect_all("sub", 4'd8, 0, 0, 0, 8'h00, 0, 0, 4'h7, 1, 4'h1, 4'h2, 3'b010);
        step();
        expect_fetch("fetch_sub");

        // Unassigned opcode behaves as NOOP
        IR = 16'hF000;
        step();
        expect_idle("dec_f", 4'd2);
        step();
        expect_idle("noop_f", 4'd3);
        step();
        expect_fetch("fetch_nop");

        // HALT holds until reset
        IR = 16'h5000;
        step();
        expect_idle("dec_halt", 4'd2);
        for (int i = 0; i < 20; i++) begin
            step();
            expect_idle("halt", 4'd9);
        end
        #2;
        Reset_N = 1'b0;
        #1;
        expect_init("rst_halt");
        @(negedge Clk);
        Reset_N = 1'b1;
        step();
        expect_fetch("fetch_end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
